// File: rtl/imem_line_buffer_pkg.sv
// Shared types for the instruction-side line buffer.
// Word types, the fetch-stage NOP and the one-hot fill states.
package imem_line_buffer_pkg;

    typedef logic [31:0] address_t;
    typedef logic [31:0] inst_t;

    localparam inst_t NOP_INST = {6'd24, 26'b0};

    localparam int S_IDLE_BIT = 0;
    localparam int S_REQ_BIT  = 1;
    localparam int S_FILL_BIT = 2;

    typedef enum logic [2:0] {
        S_IDLE = 3'b001,
        S_REQ  = 3'b010,
        S_FILL = 3'b100
    } imem_lb_state_t;

endpackage

// File: rtl/imem_line_buffer_store.sv
// Word array backing the single cached line.
// One write port for fill beats, one registered read port.
module imem_line_buffer_store
    import imem_line_buffer_pkg::*;
#(
    parameter int                LINE_WORDS = 8,
    parameter int                DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_DATA = '0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          wr_en,
    input  logic [$clog2(LINE_WORDS)-1:0] wr_idx,
    input  logic [DATA_WIDTH-1:0]         wr_data,
    input  logic                          rd_en,
    input  logic [$clog2(LINE_WORDS)-1:0] rd_idx,
    output logic [DATA_WIDTH-1:0]         rd_data
);

    logic [DATA_WIDTH-1:0] mem [LINE_WORDS];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // Read data holds between hits so the client sees a stable word.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_data <= RESET_DATA;
        end else if (rd_en) begin
            rd_data <= mem[rd_idx];
        end
    end

endmodule

// File: rtl/imem_line_buffer.sv
// Single-line instruction buffer answering fetch requests.
// Misses stall the client and refill the line from the backing bus.
module imem_line_buffer #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WORDS = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  we,
    input  logic [DATA_WIDTH-1:0] data_w,
    input  logic [3:0]            be,
    output logic [DATA_WIDTH-1:0] data_r,
    output logic                  delay,
    input  logic                  inval,
    output logic                  bus_req,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    input  logic                  bus_gnt,
    input  logic                  bus_rvalid,
    input  logic [DATA_WIDTH-1:0] bus_rdata
);

    import imem_line_buffer_pkg::*;

    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int TAG_W = ADDR_WIDTH - OFF_W;
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);
    localparam logic [DATA_WIDTH-1:0] NOP_WORD = DATA_WIDTH'(NOP_INST);

    imem_lb_state_t state_q;
    imem_lb_state_t state_d;

    logic                  valid_q;
    logic [TAG_W-1:0]      tag_q;
    logic [ADDR_WIDTH-1:0] bus_addr_q;
    logic [OFF_W-1:0]      cnt_q;
    logic                  delay_q;
    logic                  inval_seen_q;

    logic             is_idle;
    logic             is_req;
    logic             is_fill;
    logic [TAG_W-1:0] req_tag;
    logic             hit;
    logic             miss;
    logic             rd_en;
    logic             wr_en;
    logic             last_beat;
    logic             unused_ok;

    assign is_idle   = state_q[S_IDLE_BIT];
    assign is_req    = state_q[S_REQ_BIT];
    assign is_fill   = state_q[S_FILL_BIT];
    assign req_tag   = addr[ADDR_WIDTH-1:OFF_W];
    assign hit       = valid_q && (tag_q == req_tag);
    assign miss      = is_idle && en && !hit;
    assign rd_en     = is_idle && en && hit;
    assign wr_en     = is_fill && bus_rvalid;
    assign last_beat = wr_en && (cnt_q == LAST_BEAT);
    assign unused_ok = ^{we, data_w, be};

    always_comb begin
        state_d = state_q;
        unique case (1'b1)
            is_idle: if (en && !hit) state_d = S_REQ;
            is_req:  if (bus_gnt)    state_d = S_FILL;
            is_fill: if (last_beat)  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q      <= 1'b0;
            tag_q        <= '0;
            bus_addr_q   <= '0;
            cnt_q        <= '0;
            delay_q      <= 1'b0;
            inval_seen_q <= 1'b0;
        end else begin
            // Stays high through the first idle cycle after a fill,
            // because the re-presented address is only read then.
            delay_q <= !is_idle || miss;
            if (is_idle) begin
                inval_seen_q <= 1'b0;
                if (inval || miss) valid_q <= 1'b0;
                if (miss) bus_addr_q <= {req_tag, {OFF_W{1'b0}}};
            end
            if (!is_idle && inval) inval_seen_q <= 1'b1;
            if (is_req && bus_gnt) cnt_q <= '0;
            if (wr_en) cnt_q <= cnt_q + 1'b1;
            if (last_beat) begin
                tag_q        <= bus_addr_q[ADDR_WIDTH-1:OFF_W];
                valid_q      <= !(inval_seen_q || inval);
                inval_seen_q <= 1'b0;
            end
        end
    end

    imem_line_buffer_store #(
        .LINE_WORDS (LINE_WORDS),
        .DATA_WIDTH (DATA_WIDTH),
        .RESET_DATA (NOP_WORD)
    ) u_store (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_idx  (cnt_q),
        .wr_data (bus_rdata),
        .rd_en   (rd_en),
        .rd_idx  (addr[OFF_W-1:0]),
        .rd_data (data_r)
    );

    assign delay    = delay_q;
    assign bus_req  = is_req;
    assign bus_addr = bus_addr_q;

endmodule
